// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU/MDU: ALUOp values, Funct codes,
// legacy 4-bit operation codes and the MDU state type.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_M   = 2'b11;

  // Funct = {funct7[5], funct3}
  localparam logic [3:0] F_ADD  = 4'b0000;
  localparam logic [3:0] F_SUB  = 4'b1000;
  localparam logic [3:0] F_AND  = 4'b0111;
  localparam logic [3:0] F_OR   = 4'b0110;
  localparam logic [3:0] F_XOR  = 4'b0100;
  localparam logic [3:0] F_SLT  = 4'b0010;
  localparam logic [3:0] F_SLTU = 4'b0011;
  localparam logic [3:0] F_SLL  = 4'b0001;
  localparam logic [3:0] F_SRL  = 4'b0101;
  localparam logic [3:0] F_SRA  = 4'b1101;
  localparam logic [3:0] F_BLT  = 4'b0100;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_BLT  = 4'b1110;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} mdu_state_e;

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-divide step per
// cycle on unsigned magnitudes, XLEN steps per operation.
module alu_mdu_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_kill,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic              o_done,
  output logic [2*XLEN-1:0] o_acc
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_is_div;

  logic [XLEN:0]     w_madd;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_mul_next;
  logic [2*XLEN-1:0] w_div_next;

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    w_madd     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_mul_next = {w_madd, r_acc[XLEN-1:1]};
    w_shift    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_diff     = w_shift - {1'b0, r_b};
    w_div_next = w_diff[XLEN] ? {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                              : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
    end else if (i_kill) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_acc    <= {{XLEN{1'b0}}, i_a};
      r_b      <= i_b;
      r_cnt    <= CW'(XLEN - 1);
      r_busy   <= 1'b1;
      r_is_div <= i_is_div;
    end else if (r_busy) begin
      r_acc <= r_is_div ? w_div_next : w_mul_next;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_done = r_busy && (r_cnt == '0);
  assign o_acc  = r_acc;

endmodule

// File: rtl/alu_mdu_seq.sv
// EX-stage ALU with registered result and valid/ready handshake; ALUOp=11 runs an
// iterative RV32M multiply/divide and holds off new work until it completes.
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned FUNCT_W = 4,
  parameter bit          MDU_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         ALUOp,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic [XLEN-1:0]    op_a,
  input  logic [XLEN-1:0]    op_b,
  input  logic               kill,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result,
  output logic               zero,
  output logic               illegal,
  output logic [3:0]         Operation
);

  localparam int unsigned SHW = $clog2(XLEN);

  mdu_state_e r_state, w_state_next;

  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_illegal;
  logic [3:0]      r_op;

  logic [2:0]      r_f3;
  logic            r_neg;
  logic            r_fix;
  logic [XLEN-1:0] r_fix_res;

  logic w_in_ready, w_accept, w_is_m, w_mdu_go, w_single;

  // ---------------- single-cycle path ----------------
  logic [3:0]             w_funct;
  logic [SHW-1:0]         w_shamt;
  logic [XLEN-1:0]        w_sum, w_diff, w_sll, w_srl;
  logic signed [XLEN-1:0] w_sra;
  logic                   w_slt, w_sltu;
  logic [XLEN-1:0]        w_alu_res;
  logic [3:0]             w_alu_op;
  logic                   w_alu_ill, w_alu_zero;

  assign w_funct = 4'(Funct);
  assign w_shamt = op_b[SHW-1:0];
  assign w_sum   = op_a + op_b;
  assign w_diff  = op_a - op_b;
  assign w_sll   = op_a << w_shamt;
  assign w_srl   = op_a >> w_shamt;
  assign w_sra   = $signed(op_a) >>> w_shamt;
  assign w_slt   = $signed(op_a) < $signed(op_b);
  assign w_sltu  = op_a < op_b;

  always_comb begin
    w_alu_res = '0;
    w_alu_op  = OP_ADD;
    w_alu_ill = 1'b0;
    unique case (ALUOp)
      ALUOP_ADD: w_alu_res = w_sum;
      ALUOP_BR: begin
        if (w_funct == F_BLT) begin
          w_alu_res = {{(XLEN-1){1'b0}}, w_slt};
          w_alu_op  = OP_BLT;
        end else begin
          w_alu_res = w_diff;
          w_alu_op  = OP_SUB;
        end
      end
      ALUOP_R: begin
        case (w_funct)
          F_ADD:  begin w_alu_res = w_sum;                        w_alu_op = OP_ADD;  end
          F_SUB:  begin w_alu_res = w_diff;                       w_alu_op = OP_SUB;  end
          F_AND:  begin w_alu_res = op_a & op_b;                  w_alu_op = OP_AND;  end
          F_OR:   begin w_alu_res = op_a | op_b;                  w_alu_op = OP_OR;   end
          F_XOR:  begin w_alu_res = op_a ^ op_b;                  w_alu_op = OP_XOR;  end
          F_SLT:  begin w_alu_res = {{(XLEN-1){1'b0}}, w_slt};    w_alu_op = OP_SLT;  end
          F_SLTU: begin w_alu_res = {{(XLEN-1){1'b0}}, w_sltu};   w_alu_op = OP_SLTU; end
          F_SLL:  begin w_alu_res = w_sll;                        w_alu_op = OP_SLL;  end
          F_SRL:  begin w_alu_res = w_srl;                        w_alu_op = OP_SRL;  end
          F_SRA:  begin w_alu_res = w_sra;                        w_alu_op = OP_SRA;  end
          default: w_alu_ill = 1'b1;
        endcase
      end
      default: w_alu_ill = 1'b1;
    endcase
  end

  // Branch compare reports operand equality rather than result==0 (blt yields 0/1).
  assign w_alu_zero = (ALUOp == ALUOP_BR) ? (op_a == op_b) : (w_alu_res == '0);

  // ---------------- handshake ----------------
  assign w_in_ready = (r_state == StIdle) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready && !kill;
  assign w_is_m     = (ALUOp == ALUOP_M);
  assign w_mdu_go   = w_accept && w_is_m && MDU_EN;
  assign w_single   = w_accept && !(w_is_m && MDU_EN);

  // ---------------- MDU operand preparation ----------------
  logic [2:0]      w_f3;
  logic            w_m_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_res_neg;
  logic            w_div0, w_ovf, w_fix;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_fix_res;

  assign w_f3      = Funct[2:0];
  assign w_m_div   = w_f3[2];
  assign w_a_sgn   = w_m_div ? !w_f3[0] : (w_f3 != 3'b011);
  assign w_b_sgn   = w_m_div ? !w_f3[0] : !w_f3[1];
  assign w_a_neg   = w_a_sgn && op_a[XLEN-1];
  assign w_b_neg   = w_b_sgn && op_b[XLEN-1];
  assign w_mag_a   = w_a_neg ? (~op_a + 1'b1) : op_a;
  assign w_mag_b   = w_b_neg ? (~op_b + 1'b1) : op_b;
  // Remainder takes the dividend's sign; products and quotients the xor of both.
  assign w_res_neg = (w_m_div && w_f3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_div0    = w_m_div && (op_b == '0);
  assign w_ovf     = w_m_div && !w_f3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  assign w_fix     = w_div0 || w_ovf;
  assign w_fix_res = w_div0 ? (w_f3[1] ? op_a : '1) : (w_f3[1] ? '0 : op_a);

  logic              w_iter_done;
  logic [2*XLEN-1:0] w_acc;

  if (MDU_EN) begin : g_mdu
    alu_mdu_iter #(
      .XLEN (XLEN)
    ) u_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (w_mdu_go && !w_fix),
      .i_kill   (kill),
      .i_is_div (w_m_div),
      .i_a      (w_mag_a),
      .i_b      (w_mag_b),
      .o_done   (w_iter_done),
      .o_acc    (w_acc)
    );
  end else begin : g_no_mdu
    assign w_iter_done = 1'b0;
    assign w_acc       = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f3      <= '0;
      r_neg     <= 1'b0;
      r_fix     <= 1'b0;
      r_fix_res <= '0;
    end else if (w_mdu_go) begin
      r_f3      <= w_f3;
      r_neg     <= w_res_neg;
      r_fix     <= w_fix;
      r_fix_res <= w_fix_res;
    end
  end

  // ---------------- MDU sign fixup ----------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_dsel, w_dres, w_mdu_res;
  logic [3:0]        w_mdu_op;

  always_comb begin
    w_prod = r_neg ? (~w_acc + 1'b1) : w_acc;
    w_dsel = r_f3[1] ? w_acc[2*XLEN-1:XLEN] : w_acc[XLEN-1:0];
    w_dres = r_neg ? (~w_dsel + 1'b1) : w_dsel;
    if (r_fix) begin
      w_mdu_res = r_fix_res;
    end else if (r_f3[2]) begin
      w_mdu_res = w_dres;
    end else if (r_f3[1:0] == 2'b00) begin
      w_mdu_res = w_prod[XLEN-1:0];
    end else begin
      w_mdu_res = w_prod[2*XLEN-1:XLEN];
    end
    w_mdu_op = r_f3[2] ? OP_DIV : OP_MUL;
  end

  // ---------------- FSM ----------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_mdu_go) begin
          w_state_next = w_fix ? StDone : (w_m_div ? StDiv : StMul);
        end
      end
      StMul, StDiv: begin
        if (w_iter_done) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (kill) w_state_next = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_op        <= '0;
    end else if (kill) begin
      r_out_valid <= 1'b0;
    end else if (w_single) begin
      r_out_valid <= 1'b1;
      r_result    <= w_alu_res;
      r_zero      <= w_alu_zero;
      r_illegal   <= w_alu_ill;
      r_op        <= w_alu_op;
    end else if (r_state == StDone) begin
      r_out_valid <= 1'b1;
      r_result    <= w_mdu_res;
      r_zero      <= (w_mdu_res == '0);
      r_illegal   <= 1'b0;
      r_op        <= w_mdu_op;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;
  assign Operation = r_op;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed self-checking bench for alu_mdu_seq (XLEN=32, MDU enabled).
module tb_alu_mdu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALUOp;
  logic [3:0]  Funct;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [3:0]  Operation;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mdu_seq #(
    .XLEN    (32),
    .FUNCT_W (4),
    .MDU_EN  (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUOp     (ALUOp),
    .Funct     (Funct),
    .op_a      (op_a),
    .op_b      (op_b),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .Operation (Operation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for exactly one edge; returns 1 time unit after that edge.
  task automatic issue(input logic [1:0] op, input logic [3:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    ALUOp    = op;
    Funct    = f;
    op_a     = a;
    op_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Latency counts from the accept edge (1 = visible right after it).
  task automatic wait_out(output int lat, output int rdy_seen);
    lat      = 1;
    rdy_seen = 0;
    while (!out_valid && lat < 60) begin
      if (in_ready) rdy_seen++;
      tick();
      lat++;
    end
  endtask

  int lat;
  int rdy;
  int seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; ALUOp = 2'b00; Funct = 4'h0;
    op_a = '0; op_b = '0; kill = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst result", 64'(result), 64'd0);
    chk("rst zero", 64'(zero), 64'd0);
    chk("rst illegal", 64'(illegal), 64'd0);
    chk("rst Operation", 64'(Operation), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    issue(2'b10, 4'b1000, 32'd5, 32'd7);
    chk("sub valid", 64'(out_valid), 64'd1);
    chk("sub result", 64'(result), 64'hFFFFFFFE);
    chk("sub Operation", 64'(Operation), 64'h6);
    chk("sub zero", 64'(zero), 64'd0);
    chk("sub in_ready", 64'(in_ready), 64'd1);

    issue(2'b01, 4'b0100, 32'hFFFFFFFD, 32'd2);
    chk("blt result", 64'(result), 64'd1);
    chk("blt Operation", 64'(Operation), 64'hE);
    chk("blt zero", 64'(zero), 64'd0);

    issue(2'b01, 4'b0000, 32'd9, 32'd9);
    chk("beq zero", 64'(zero), 64'd1);
    chk("beq Operation", 64'(Operation), 64'h6);

    issue(2'b00, 4'b1111, 32'd3, 32'd4);
    chk("add result", 64'(result), 64'd7);
    chk("add Operation", 64'(Operation), 64'h2);

    issue(2'b10, 4'b1101, 32'h80000000, 32'd4);
    chk("sra result", 64'(result), 64'hF8000000);
    chk("sra Operation", 64'(Operation), 64'hA);

    issue(2'b10, 4'b0011, 32'd1, 32'hFFFFFFFF);
    chk("sltu result", 64'(result), 64'd1);
    chk("sltu Operation", 64'(Operation), 64'hF);

    issue(2'b10, 4'b1111, 32'd3, 32'd4);
    chk("ill flag", 64'(illegal), 64'd1);
    chk("ill result", 64'(result), 64'd0);
    chk("ill Operation", 64'(Operation), 64'h2);

    // MULH
    issue(2'b11, 4'b0001, 32'h80000000, 32'd2);
    wait_out(lat, rdy);
    chk("mulh latency", 64'(lat), 64'd34);
    chk("mulh in_ready busy", 64'(rdy), 64'd0);
    chk("mulh result", 64'(result), 64'hFFFFFFFF);
    chk("mulh Operation", 64'(Operation), 64'hB);

    issue(2'b11, 4'b0000, 32'd7, 32'hFFFFFFFD);
    wait_out(lat, rdy);
    chk("mul result", 64'(result), 64'hFFFFFFEB);

    issue(2'b11, 4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_out(lat, rdy);
    chk("mulhu result", 64'(result), 64'hFFFFFFFE);

    issue(2'b11, 4'b0100, 32'hFFFFFFF9, 32'd2);
    wait_out(lat, rdy);
    chk("div latency", 64'(lat), 64'd34);
    chk("div result", 64'(result), 64'hFFFFFFFD);
    chk("div Operation", 64'(Operation), 64'hC);

    issue(2'b11, 4'b0110, 32'hFFFFFFF9, 32'd2);
    wait_out(lat, rdy);
    chk("rem result", 64'(result), 64'hFFFFFFFF);

    issue(2'b11, 4'b0100, 32'd7, 32'd0);
    wait_out(lat, rdy);
    chk("div0 latency", 64'(lat), 64'd2);
    chk("div0 result", 64'(result), 64'hFFFFFFFF);

    issue(2'b11, 4'b0110, 32'd7, 32'd0);
    wait_out(lat, rdy);
    chk("rem0 latency", 64'(lat), 64'd2);
    chk("rem0 result", 64'(result), 64'd7);

    issue(2'b11, 4'b0100, 32'h80000000, 32'hFFFFFFFF);
    wait_out(lat, rdy);
    chk("ovf latency", 64'(lat), 64'd2);
    chk("ovf result", 64'(result), 64'h80000000);

    // Backpressure: held result, then pending op accepted on the consume cycle
    issue(2'b00, 4'b0000, 32'd1, 32'd2);
    out_ready = 1'b0;
    in_valid = 1'b1; ALUOp = 2'b00; Funct = 4'h0; op_a = 32'd100; op_b = 32'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp valid", 64'(out_valid), 64'd1);
      chk("bp result", 64'(result), 64'd3);
      chk("bp in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp next result", 64'(result), 64'd100);
    chk("bp next valid", 64'(out_valid), 64'd1);

    // Kill during DIV
    issue(2'b11, 4'b0100, 32'd100, 32'd7);
    for (int i = 0; i < 4; i++) tick();
    kill = 1'b1;
    in_valid = 1'b1; ALUOp = 2'b00; op_a = 32'd1; op_b = 32'd1;
    tick();
    kill = 1'b0; in_valid = 1'b0;
    chk("kill out_valid", 64'(out_valid), 64'd0);
    chk("kill in_ready", 64'(in_ready), 64'd1);
    issue(2'b00, 4'b0000, 32'd5, 32'd5);
    chk("post-kill valid", 64'(out_valid), 64'd1);
    chk("post-kill result", 64'(result), 64'd10);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("kill no stale result", 64'(seen), 64'd0);

    // kill together with in_valid at idle: not accepted
    kill = 1'b1;
    in_valid = 1'b1; ALUOp = 2'b00; op_a = 32'd2; op_b = 32'd2;
    tick();
    kill = 1'b0; in_valid = 1'b0;
    chk("kill+valid ignored", 64'(out_valid), 64'd0);

    // Async reset mid-MUL
    issue(2'b11, 4'b0000, 32'd3, 32'd5);
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst result", 64'(result), 64'd0);
    chk("midrst in_ready", 64'(in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("midrst no stale", 64'(seen), 64'd0);
    chk("midrst in_ready after", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
